// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor; BPC operand bits per clock through one full-adder slice.
// Latency: STEPS = WIDTH/BPC clocks from the accepting edge to the one-cycle done pulse.
// Backpressure: start is sampled only while busy=0; starts during RUN are dropped, never queued.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             SUB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             OVF
);

   // Number of slice passes per operation; derived from WIDTH and BPC, not overridable.
   localparam int STEPS = WIDTH / BPC;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   // Reject illegal geometries at elaboration rather than producing a silently wrong adder.
   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2");
   end
   if ((BPC < 1) || (BPC > WIDTH) || ((WIDTH % BPC) != 0)) begin : g_bad_bpc
      $error("serial_adder: BPC must divide WIDTH");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_step;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_c;
   logic             r_ovf;
   logic             r_done;

   logic [BPC-1:0]       w_slice;
   logic                 w_cout;
   logic                 w_c_msb;
   logic [WIDTH+BPC-1:0] w_cat;
   logic [WIDTH-1:0]     w_res_nxt;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and step control; the done cycle is already IDLE so a start there is accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // BPC-wide ripple slice; also exposes the carry entering the slice's top bit, which on the
   // final step is the carry into the operand MSB needed for signed overflow.
   always_comb begin
      logic l_c;
      l_c     = r_carry;
      w_c_msb = r_carry;
      w_slice = '0;
      for (int i = 0; i < BPC; i++) begin
         if (i == BPC - 1) begin
            w_c_msb = l_c;
         end
         w_slice[i] = r_a[i] ^ r_b[i] ^ l_c;
         l_c        = (r_a[i] & r_b[i]) | (l_c & (r_a[i] ^ r_b[i]));
      end
      w_cout = l_c;
   end

   // Sum bits enter the result shift register from the MSB side; written as a concat-and-slice
   // so BPC == WIDTH (single step) needs no special case.
   assign w_cat     = {w_slice, r_res};
   assign w_res_nxt = w_cat[WIDTH+BPC-1:BPC];

   // Operand/result shifting, carry and step counter; the visible result only updates on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_c     <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            // Subtract is A + ~B + 1, with borrow-in folding into the initial carry.
            r_a     <= A;
            r_b     <= B ^ {WIDTH{SUB}};
            r_carry <= Cin ^ SUB;
            r_cnt   <= '0;
         end else if (w_step) begin
            r_a     <= r_a >> BPC;
            r_b     <= r_b >> BPC;
            r_res   <= w_res_nxt;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_s    <= w_res_nxt;
               r_c    <= w_cout;
               r_ovf  <= w_c_msb ^ w_cout;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_state == ST_RUN);
   assign done = r_done;
   assign S    = r_s;
   assign C    = r_c;
   assign OVF  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: BPC=1 and BPC=4 instances driven from shared operand inputs.
// Directed table vectors, hand-written handshake/reset sequences and a random reference-model run.
// Each DUT has its own start so one can be exercised while the other stays idle.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start1, start4;
   logic [7:0] A, B;
   logic       Cin, SUB;
   logic       busy1, done1, C1, OVF1;
   logic       busy4, done4, C4, OVF4;
   logic [7:0] S1, S4;

   int         sel;
   logic       busy_s, done_s, C_s, OVF_s;
   logic [7:0] S_s;

   int         checks;
   int         errors;
   int         cyc;
   logic [9:0] hold_v;
   string      tag;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       ovf;
   } vec_t;

   vec_t tbl[10];

   serial_adder #(.WIDTH(8), .BPC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
      .busy(busy1), .done(done1), .S(S1), .C(C1), .OVF(OVF1)
   );

   serial_adder #(.WIDTH(8), .BPC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
      .busy(busy4), .done(done4), .S(S4), .C(C4), .OVF(OVF4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign busy_s = (sel == 4) ? busy4 : busy1;
   assign done_s = (sel == 4) ? done4 : done1;
   assign S_s    = (sel == 4) ? S4    : S1;
   assign C_s    = (sel == 4) ? C4    : C1;
   assign OVF_s  = (sel == 4) ? OVF4  : OVF1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   // One clock; while no completion is showing, the visible result must not move.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (done_s !== 1'b1) chk("hold", {C_s, OVF_s, S_s}, hold_v);
   endtask

   // Present an operation and pulse start for exactly one edge (called away from the clock edge).
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
      A = a; B = b; Cin = cin; SUB = sub;
      if (sel == 4) start4 = 1'b1;
      else          start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start4 = 1'b0;
      cyc    = 0;
      chk("accept_busy", busy_s, 1);
      chk("accept_done", done_s, 0);
      chk("accept_hold", {C_s, OVF_s, S_s}, hold_v);
   endtask

   // Wait (bounded) for done, then check latency and the result; returns inside the done cycle.
   task automatic finish(input logic [7:0] s, input logic c, input logic ovf);
      int lat;
      lat = (sel == 4) ? 2 : 8;
      while (done_s !== 1'b1 && cyc < 40) tick();
      chk("latency", cyc, lat);
      chk("S", S_s, s);
      chk("C", C_s, c);
      chk("OVF", OVF_s, ovf);
      chk("busy_at_done", busy_s, 0);
      hold_v = {c, ovf, s};
   endtask

   // Done must be a single-cycle pulse, with the block back to idle.
   task automatic pulse_end();
      tick();
      chk("done_pulse", done_s, 0);
      chk("idle", busy_s, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      hold_v = '0;
   endtask

   task automatic rand_run(input int n);
      logic [7:0] a, b, bb, es;
      logic       cin, sub, ec, eo;
      logic [8:0] sum9;
      for (int k = 0; k < n; k++) begin
         a    = 8'($urandom_range(0, 255));
         b    = 8'($urandom_range(0, 255));
         cin  = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         bb   = b ^ {8{sub}};
         sum9 = {1'b0, a} + {1'b0, bb} + {8'd0, cin ^ sub};
         es   = sum9[7:0];
         ec   = sum9[8];
         eo   = (a[7] == bb[7]) && (es[7] != a[7]);
         launch(a, b, cin, sub);
         finish(es, ec, eo);
      end
   endtask

   task automatic run_table();
      for (int i = 0; i < 10; i++) begin
         tag = $sformatf("tbl%0d_bpc%0d", i, sel);
         launch(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
         finish(tbl[i].s, tbl[i].c, tbl[i].ovf);
         pulse_end();
      end
   endtask

   initial begin
      int seen;
      checks = 0; errors = 0; cyc = 0; sel = 1; hold_v = '0; tag = "init";
      //            a      b      cin   sub   s      c     ovf
      tbl[0] = '{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
      tbl[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[7] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      tbl[8] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[9] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

      // Reset asserted mid-cycle with start held high throughout.
      rst_n = 1'b1; start1 = 1'b1; start4 = 1'b1;
      A = 8'h3C; B = 8'h45; Cin = 1'b0; SUB = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      tag = "reset";
      chk("busy1", busy1, 0); chk("done1", done1, 0); chk("S1", S1, 0);
      chk("C1", C1, 0);       chk("OVF1", OVF1, 0);
      chk("busy4", busy4, 0); chk("S4", S4, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("busy1_held", busy1, 0); chk("done1_held", done1, 0); chk("busy4_held", busy4, 0);
      start1 = 1'b0; start4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_after_reset", busy1, 0);

      // Add with signed overflow; result must stay 00 through RUN.
      tag = "add_ovf";
      launch(8'h3C, 8'h45, 1'b0, 1'b0);
      finish(8'h81, 1'b0, 1'b1);
      pulse_end();

      tag = "carry_in";
      launch(8'hFF, 8'h01, 1'b1, 1'b0);
      finish(8'h01, 1'b1, 1'b0);
      pulse_end();

      // Subtract with borrow, then a start in the done cycle with no idle gap.
      tag = "sub_borrow";
      launch(8'h10, 8'h20, 1'b0, 1'b1);
      finish(8'hF0, 1'b0, 1'b0);
      tag = "back_to_back";
      launch(8'h80, 8'h01, 1'b0, 1'b1);
      finish(8'h7F, 1'b1, 1'b1);
      pulse_end();

      // Start pulsed 3 clocks into RUN with other operands is ignored.
      tag = "start_busy";
      launch(8'h3C, 8'h45, 1'b0, 1'b0);
      repeat (3) tick();
      A = 8'h00; B = 8'h00; Cin = 1'b1; SUB = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0; A = 8'h5A; B = 8'hA5;
      finish(8'h81, 1'b0, 1'b1);
      pulse_end();

      // Reset 3 clocks into RUN: operation abandoned, outputs cleared, no done.
      tag = "rst_mid";
      launch(8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("busy", busy1, 0); chk("done", done1, 0); chk("S", S1, 0);
      chk("C", C1, 0);       chk("OVF", OVF1, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hold_v = '0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done1 === 1'b1 || busy1 === 1'b1) seen++;
      end
      chk("no_done_after_rst", seen, 0);

      tag = "fresh";
      launch(8'h7F, 8'h01, 1'b0, 1'b0);
      finish(8'h80, 1'b0, 1'b1);
      pulse_end();

      run_table();
      tag = "rand_bpc1";
      rand_run(1000);
      pulse_end();

      // BPC=4 instance: reset for a known baseline, then the same vectors.
      do_reset();
      sel = 4;
      tag = "bpc4_add";
      launch(8'h3C, 8'h45, 1'b0, 1'b0);
      finish(8'h81, 1'b0, 1'b1);
      pulse_end();
      run_table();
      tag = "rand_bpc4";
      rand_run(1000);
      pulse_end();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
